// File: rtl/controller_sequencer.sv
// SAP-1 control unit: one-hot T-state ring (T1..T6) plus a HALT state,
// with Moore decode of the control word from (state, opcode).
module controller_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter bit SKIP_IDLE = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_increment,
    output logic                pc_output_to_bus,
    output logic                mar_load,
    output logic                ram_output_to_bus,
    output logic                ir_load,
    output logic                ir_output_to_bus,
    output logic                a_load,
    output logic                a_output_to_bus,
    output logic                alu_subtract,
    output logic                alu_output_to_bus,
    output logic                b_load,
    output logic                out_load,
    output logic                halted,
    output logic [5:0]          t_state
);

    // Bit 6 is HALT; bits 5:0 are the T1..T6 ring.
    localparam logic [6:0] S_T1   = 7'b000_0001;
    localparam logic [6:0] S_T2   = 7'b000_0010;
    localparam logic [6:0] S_T3   = 7'b000_0100;
    localparam logic [6:0] S_T4   = 7'b000_1000;
    localparam logic [6:0] S_T5   = 7'b001_0000;
    localparam logic [6:0] S_T6   = 7'b010_0000;
    localparam logic [6:0] S_HALT = 7'b100_0000;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    logic [6:0] state_q, state_d;
    logic       is_lda, is_add, is_sub, is_out, is_hlt, is_mem;

    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);
    // Instructions that fetch an operand from RAM in T4/T5.
    assign is_mem = is_lda | is_add | is_sub;

    // Next-state: step the ring, shortcut to T1 when SKIP_IDLE, any illegal encoding recovers to T1.
    always_comb begin
        state_d = S_T1;
        case (state_q)
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = S_T4;
            S_T4: begin
                if (is_hlt)                 state_d = S_HALT;
                else if (SKIP_IDLE && !is_mem) state_d = S_T1;
                else                        state_d = S_T5;
            end
            S_T5: begin
                if (SKIP_IDLE && !(is_add || is_sub)) state_d = S_T1;
                else                                  state_d = S_T6;
            end
            S_T6:   state_d = S_T1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    // State register; reset aborts any instruction and restarts at T1.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_T1;
        else       state_q <= state_d;
    end

    logic cp_c, ep_c, lm_c, ce_c, li_c, ei_c, la_c, ea_c, su_c, eu_c, lb_c, lo_c;
    logic [5:0] t_c;

    // Moore decode of the control word; stable for the whole cycle.
    always_comb begin
        cp_c = 1'b0; ep_c = 1'b0; lm_c = 1'b0; ce_c = 1'b0;
        li_c = 1'b0; ei_c = 1'b0; la_c = 1'b0; ea_c = 1'b0;
        su_c = 1'b0; eu_c = 1'b0; lb_c = 1'b0; lo_c = 1'b0;
        t_c  = 6'b0;
        case (state_q)
            S_T1: begin ep_c = 1'b1; lm_c = 1'b1; end
            S_T2: cp_c = 1'b1;
            S_T3: begin ce_c = 1'b1; li_c = 1'b1; end
            S_T4: begin
                if (is_mem) begin
                    ei_c = 1'b1; lm_c = 1'b1;
                end else if (is_out) begin
                    ea_c = 1'b1; lo_c = 1'b1;
                end
            end
            S_T5: begin
                if (is_lda) begin
                    ce_c = 1'b1; la_c = 1'b1;
                end else if (is_add || is_sub) begin
                    ce_c = 1'b1; lb_c = 1'b1;
                end
            end
            S_T6: begin
                if (is_add || is_sub) begin
                    eu_c = 1'b1; la_c = 1'b1; su_c = is_sub;
                end
            end
            default: ;
        endcase
        case (state_q)
            S_T1, S_T2, S_T3, S_T4, S_T5, S_T6: t_c = state_q[5:0];
            default: t_c = 6'b0;
        endcase
    end

    // Reset gates every control strobe so the datapath sees nothing while it is held.
    assign pc_increment      = cp_c & ~reset;
    assign pc_output_to_bus  = ep_c & ~reset;
    assign mar_load          = lm_c & ~reset;
    assign ram_output_to_bus = ce_c & ~reset;
    assign ir_load           = li_c & ~reset;
    assign ir_output_to_bus  = ei_c & ~reset;
    assign a_load            = la_c & ~reset;
    assign a_output_to_bus   = ea_c & ~reset;
    assign alu_subtract      = su_c & ~reset;
    assign alu_output_to_bus = eu_c & ~reset;
    assign b_load            = lb_c & ~reset;
    assign out_load          = lo_c & ~reset;
    assign halted            = (state_q == S_HALT);
    assign t_state           = t_c;

endmodule
